// File: rtl/screen_menu_pkg.sv
//------------------------------------------------------------------------------
// Module   : screen_menu_pkg
// Brief    : Shared colours, blink period and FSM state type for the menu screen
// Revision : 1.0 - initial N-option menu release
//------------------------------------------------------------------------------
`default_nettype none

package screen_menu_pkg;

    localparam logic [7:0] COLOR_WHITE         = 8'hFF;
    localparam logic [7:0] COLOR_DEFAULT       = 8'h00;
    localparam logic [7:0] COLOR_MENU_SELECTED = 8'hE0;
    localparam int         MENU_BLINK_PERIOD   = 12_500_000;

    typedef enum logic [1:0] {
        MENU_IDLE   = 2'd0,
        MENU_ACTIVE = 2'd1,
        MENU_LOCKED = 2'd2
    } menu_state_t;

    // A single-option index would otherwise collapse to zero bits.
    function automatic int idxWidth(input int numOptions);
        return (numOptions > 1) ? $clog2(numOptions) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/screen_menu_controller.sv
//------------------------------------------------------------------------------
// Module   : screen_menu_controller
// Brief    : Menu FSM with key edge detection, cursor stepping, blink and colours
// Revision : 1.0 - initial N-option menu release
//------------------------------------------------------------------------------
`default_nettype none

module screen_menu_controller
    import screen_menu_pkg::*;
#(
    parameter int  NUM_OPTIONS   = 2,
    parameter int  DEFAULT_INDEX = 0,
    parameter int  WRAP          = 1,
    parameter int  BLINK_EN      = 1,
    parameter int  BLINK_PERIOD  = MENU_BLINK_PERIOD,
    localparam int IDX_W         = idxWidth(NUM_OPTIONS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     keyPrevIsPressed,
    input  logic                     keyNextIsPressed,
    input  logic                     keyConfirmIsPressed,
    input  logic                     screenMenuOperational,
    output logic [8*NUM_OPTIONS-1:0] optionColors,
    output logic [IDX_W-1:0]         selectedIndex,
    output logic [IDX_W-1:0]         chosenIndex,
    output logic                     confirmed
);

    localparam int               CNT_W        = $clog2(BLINK_PERIOD);
    localparam logic [IDX_W:0]   c_lastIdx    = (IDX_W+1)'(NUM_OPTIONS - 1);
    localparam logic [IDX_W:0]   c_oneIdx     = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_defaultIdx = IDX_W'(DEFAULT_INDEX);
    localparam logic [CNT_W-1:0] c_blinkLast  = CNT_W'(BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_cntOne     = CNT_W'(1);

    menu_state_t      r_state;
    logic [IDX_W-1:0] r_selectedIndex;
    logic [IDX_W-1:0] r_chosenIndex;
    logic             r_confirmed;
    logic [CNT_W-1:0] r_blinkCnt;
    logic             r_blinkOn;
    logic             r_prevQ, r_nextQ, r_confirmQ;
    logic             r_edgePrev, r_edgeNext, r_edgeConfirm;

    logic [IDX_W:0]   w_idxWide;
    logic [IDX_W:0]   w_idxNext;
    logic [IDX_W:0]   w_idxPrev;
    logic [IDX_W:0]   w_idxMoved;
    logic             w_cursorMoves;

    // Arithmetic one bit wider so the step past the last entry is caught before truncation.
    always_comb begin
        w_idxWide = {1'b0, r_selectedIndex};
        w_idxNext = (w_idxWide == c_lastIdx) ? ((WRAP != 0) ? '0 : w_idxWide)
                                             : w_idxWide + c_oneIdx;
        w_idxPrev = (w_idxWide == '0) ? ((WRAP != 0) ? c_lastIdx : w_idxWide)
                                      : w_idxWide - c_oneIdx;
        w_idxMoved = w_idxWide;
        if (r_edgeNext && !r_edgePrev) begin
            w_idxMoved = w_idxNext;
        end else if (r_edgePrev && !r_edgeNext) begin
            w_idxMoved = w_idxPrev;
        end
        w_cursorMoves = (w_idxMoved != w_idxWide);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= MENU_IDLE;
            r_selectedIndex <= c_defaultIdx;
            r_chosenIndex   <= c_defaultIdx;
            r_confirmed     <= 1'b0;
            r_blinkCnt      <= '0;
            r_blinkOn       <= 1'b1;
            r_prevQ         <= 1'b0;
            r_nextQ         <= 1'b0;
            r_confirmQ      <= 1'b0;
            r_edgePrev      <= 1'b0;
            r_edgeNext      <= 1'b0;
            r_edgeConfirm   <= 1'b0;
        end else begin
            r_prevQ       <= keyPrevIsPressed;
            r_nextQ       <= keyNextIsPressed;
            r_confirmQ    <= keyConfirmIsPressed;
            r_edgePrev    <= keyPrevIsPressed & ~r_prevQ;
            r_edgeNext    <= keyNextIsPressed & ~r_nextQ;
            r_edgeConfirm <= keyConfirmIsPressed & ~r_confirmQ;
            r_confirmed   <= 1'b0;

            if (!screenMenuOperational) begin
                r_state    <= MENU_IDLE;
                r_blinkCnt <= '0;
                r_blinkOn  <= 1'b1;
            end else begin
                case (r_state)
                    MENU_IDLE: begin
                        r_state         <= MENU_ACTIVE;
                        r_selectedIndex <= r_chosenIndex;
                        r_blinkCnt      <= '0;
                        r_blinkOn       <= 1'b1;
                    end
                    MENU_ACTIVE: begin
                        if (r_edgeConfirm) begin
                            r_chosenIndex <= r_selectedIndex;
                            r_confirmed   <= 1'b1;
                            r_state       <= MENU_LOCKED;
                            r_blinkCnt    <= '0;
                            r_blinkOn     <= 1'b1;
                        end else if (w_cursorMoves) begin
                            r_selectedIndex <= w_idxMoved[IDX_W-1:0];
                            r_blinkCnt      <= '0;
                            r_blinkOn       <= 1'b1;
                        end else if (BLINK_EN != 0) begin
                            if (r_blinkCnt == c_blinkLast) begin
                                r_blinkCnt <= '0;
                                r_blinkOn  <= ~r_blinkOn;
                            end else begin
                                r_blinkCnt <= r_blinkCnt + c_cntOne;
                            end
                        end else begin
                            r_blinkCnt <= '0;
                            r_blinkOn  <= 1'b1;
                        end
                    end
                    MENU_LOCKED: begin
                        r_blinkCnt <= '0;
                        r_blinkOn  <= 1'b1;
                    end
                    default: begin
                        r_state <= MENU_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_OPTIONS; gi++) begin : g_optionColor
        localparam logic [IDX_W-1:0] c_myIdx = IDX_W'(gi);
        assign optionColors[8*gi +: 8] =
            ((r_state != MENU_IDLE) && (r_selectedIndex == c_myIdx) && r_blinkOn)
                ? COLOR_MENU_SELECTED : COLOR_DEFAULT;
    end

    assign selectedIndex = r_selectedIndex;
    assign chosenIndex   = r_chosenIndex;
    assign confirmed     = r_confirmed;

endmodule

`default_nettype wire

// File: rtl/screen_menu.sv
//------------------------------------------------------------------------------
// Module   : screen_menu
// Brief    : N-option menu screen: controller plus title/option pixel compositing
// Revision : 1.0 - initial N-option menu release
//------------------------------------------------------------------------------
`default_nettype none

module screen_menu
    import screen_menu_pkg::*;
#(
    parameter int  NUM_OPTIONS   = 2,
    parameter int  DEFAULT_INDEX = 0,
    parameter int  WRAP          = 1,
    parameter int  BLINK_EN      = 1,
    parameter int  BLINK_PERIOD  = MENU_BLINK_PERIOD,
    localparam int IDX_W         = idxWidth(NUM_OPTIONS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [10:0]              pixelX,
    input  logic [10:0]              pixelY,
    input  logic                     keyPrevIsPressed,
    input  logic                     keyNextIsPressed,
    input  logic                     keyConfirmIsPressed,
    input  logic                     screenMenuOperational,
    input  logic                     drawTitle,
    input  logic [7:0]               RGBTitle,
    input  logic [NUM_OPTIONS-1:0]   drawOptions,
    input  logic [8*NUM_OPTIONS-1:0] RGBOptions,
    output logic [8*NUM_OPTIONS-1:0] optionColors,
    output logic [IDX_W-1:0]         selectedIndex,
    output logic [IDX_W-1:0]         chosenIndex,
    output logic                     confirmed,
    output logic [7:0]               RGB_screen_menu
);

    logic [21:0] w_unusedPixels;
    logic [7:0]  w_rgb;

    // Pixel coordinates only travel alongside the colour stream for alignment.
    assign w_unusedPixels = {pixelX, pixelY};

    screen_menu_controller #(
        .NUM_OPTIONS   (NUM_OPTIONS),
        .DEFAULT_INDEX (DEFAULT_INDEX),
        .WRAP          (WRAP),
        .BLINK_EN      (BLINK_EN),
        .BLINK_PERIOD  (BLINK_PERIOD)
    ) u_controller (
        .clk                   (clk),
        .reset                 (reset),
        .keyPrevIsPressed      (keyPrevIsPressed),
        .keyNextIsPressed      (keyNextIsPressed),
        .keyConfirmIsPressed   (keyConfirmIsPressed),
        .screenMenuOperational (screenMenuOperational),
        .optionColors          (optionColors),
        .selectedIndex         (selectedIndex),
        .chosenIndex           (chosenIndex),
        .confirmed             (confirmed)
    );

    // Descending scan so the lowest hit option wins; the title overrides all.
    always_comb begin
        w_rgb = COLOR_WHITE;
        for (int i = NUM_OPTIONS - 1; i >= 0; i--) begin
            if (drawOptions[i]) begin
                w_rgb = RGBOptions[8*i +: 8];
            end
        end
        if (drawTitle) begin
            w_rgb = RGBTitle;
        end
    end

    assign RGB_screen_menu = w_rgb;

endmodule

`default_nettype wire

// File: tb/tb_screen_menu.sv
//------------------------------------------------------------------------------
// Module   : tb_screen_menu
// Brief    : Directed self-checking bench: wrap/blink instance A, saturate instance B
// Revision : 1.0 - initial N-option menu release
//------------------------------------------------------------------------------
`default_nettype none

module tb_screen_menu;

    localparam logic [7:0] SEL   = 8'hE0;
    localparam logic [7:0] DEF   = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;

    localparam int K_APREV = 0;
    localparam int K_ANEXT = 1;
    localparam int K_ACONF = 2;
    localparam int K_BPREV = 3;
    localparam int K_BNEXT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        op;
    logic        drawTitle;
    logic [7:0]  rgbTitle;
    logic [2:0]  drawOpts;
    logic [23:0] rgbOpts;
    logic        aPrev, aNext, aConf, bPrev, bNext, bConf;

    logic [23:0] colorsA, colorsB;
    logic [1:0]  selA, selB, chosenA, chosenB;
    logic        confA, confB;
    logic [7:0]  rgbA, rgbB;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    screen_menu #(
        .NUM_OPTIONS(3), .DEFAULT_INDEX(0), .WRAP(1), .BLINK_EN(1), .BLINK_PERIOD(4)
    ) dutA (
        .clk(clk), .reset(reset), .pixelX(11'd0), .pixelY(11'd0),
        .keyPrevIsPressed(aPrev), .keyNextIsPressed(aNext), .keyConfirmIsPressed(aConf),
        .screenMenuOperational(op), .drawTitle(drawTitle), .RGBTitle(rgbTitle),
        .drawOptions(drawOpts), .RGBOptions(rgbOpts), .optionColors(colorsA),
        .selectedIndex(selA), .chosenIndex(chosenA), .confirmed(confA),
        .RGB_screen_menu(rgbA)
    );

    screen_menu #(
        .NUM_OPTIONS(3), .DEFAULT_INDEX(0), .WRAP(0), .BLINK_EN(0), .BLINK_PERIOD(4)
    ) dutB (
        .clk(clk), .reset(reset), .pixelX(11'd0), .pixelY(11'd0),
        .keyPrevIsPressed(bPrev), .keyNextIsPressed(bNext), .keyConfirmIsPressed(bConf),
        .screenMenuOperational(op), .drawTitle(drawTitle), .RGBTitle(rgbTitle),
        .drawOptions(drawOpts), .RGBOptions(rgbOpts), .optionColors(colorsB),
        .selectedIndex(selB), .chosenIndex(chosenB), .confirmed(confB),
        .RGB_screen_menu(rgbB)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setKey(input int k, input logic v);
        case (k)
            K_APREV: aPrev = v;
            K_ANEXT: aNext = v;
            K_ACONF: aConf = v;
            K_BPREV: bPrev = v;
            K_BNEXT: bNext = v;
            default: ;
        endcase
    endtask

    // Rise, wait for the registered edge and the resulting update, then release.
    task automatic pressKey(input int k);
        setKey(k, 1'b1);
        tick();
        tick();
        setKey(k, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 1'b0;
        aPrev = 0; aNext = 0; aConf = 0; bPrev = 0; bNext = 0; bConf = 0;
        drawTitle = 0; rgbTitle = 8'h1C; drawOpts = 3'b000; rgbOpts = {8'h33, 8'h22, 8'h11};
        repeat (3) tick();
        checkValue("reset_sel", selA, 0);
        checkValue("reset_chosen", chosenA, 0);
        checkValue("reset_confirmed", confA, 0);
        checkValue("reset_colors", colorsA, 24'h0);
        reset = 1'b0;
        tick();
        op = 1'b1;
        tick();
        tick();

        // wrap stepping on A
        pressKey(K_ANEXT); checkValue("wrap_next1", selA, 1); tick();
        pressKey(K_ANEXT); checkValue("wrap_next2", selA, 2); tick();
        pressKey(K_ANEXT); checkValue("wrap_next3", selA, 0); tick();
        pressKey(K_APREV); checkValue("wrap_prev0", selA, 2); tick();

        // saturating stepping on B
        for (int n = 0; n < 5; n++) begin
            pressKey(K_BNEXT);
            checkValue("sat_next", selB, (n + 1 > 2) ? 2 : n + 1);
            tick();
        end
        for (int n = 0; n < 5; n++) begin
            pressKey(K_BPREV);
            checkValue("sat_prev", selB, (2 - (n + 1) < 0) ? 0 : 2 - (n + 1));
            tick();
        end
        checkValue("solid_b_sel0", colorsB[7:0], SEL);
        checkValue("solid_b_opt1", colorsB[15:8], DEF);

        // blink on A at cursor 1
        pressKey(K_APREV);
        checkValue("blink_sel", selA, 1);
        for (int k = 0; k < 8; k++) begin
            checkValue("blink_opt1", colorsA[15:8], (k < 4) ? SEL : DEF);
            checkValue("blink_opt0", colorsA[7:0], DEF);
            checkValue("blink_opt2", colorsA[23:16], DEF);
            tick();
        end
        tick();
        tick();
        pressKey(K_ANEXT);
        checkValue("restart_sel", selA, 2);
        checkValue("restart_opt2", colorsA[23:16], SEL);
        checkValue("restart_opt1", colorsA[15:8], DEF);
        tick();

        // confirm beats next in the same cycle
        aConf = 1'b1; aNext = 1'b1;
        tick();
        tick();
        checkValue("confirm_pulse", confA, 1);
        checkValue("confirm_chosen", chosenA, 2);
        checkValue("confirm_sel", selA, 2);
        tick();
        checkValue("confirm_oneshot", confA, 0);
        aConf = 1'b0; aNext = 1'b0;
        tick();
        pressKey(K_ANEXT);
        checkValue("locked_sel", selA, 2);
        for (int k = 0; k < 6; k++) begin
            checkValue("locked_solid", colorsA[23:16], SEL);
            tick();
        end

        // confirm held across leave and re-entry
        aConf = 1'b1;
        tick();
        tick();
        op = 1'b0;
        tick();
        checkValue("idle_colors", colorsA, 24'h0);
        checkValue("idle_confirmed", confA, 0);
        tick();
        op = 1'b1;
        tick();
        checkValue("reentry_sel", selA, 2);
        for (int k = 0; k < 6; k++) begin
            checkValue("held_no_confirm", confA, 0);
            tick();
        end
        aConf = 1'b0;
        tick();
        pressKey(K_APREV);
        checkValue("reentry_prev", selA, 1);
        tick();
        pressKey(K_ACONF);
        checkValue("repress_pulse", confA, 1);
        checkValue("repress_chosen", chosenA, 1);
        tick();
        checkValue("repress_oneshot", confA, 0);

        // compositing priority
        drawTitle = 1'b1; drawOpts = 3'b011; #1;
        checkValue("comp_title", rgbA, 8'h1C);
        drawTitle = 1'b0; drawOpts = 3'b110; #1;
        checkValue("comp_opt1", rgbA, 8'h22);
        drawOpts = 3'b100; #1;
        checkValue("comp_opt2", rgbB, 8'h33);
        drawOpts = 3'b000; #1;
        checkValue("comp_white", rgbA, WHITE);

        // unconfirmed move is discarded on re-entry
        op = 1'b0;
        tick();
        op = 1'b1;
        tick();
        checkValue("reenter2_sel", selA, 1);
        pressKey(K_ANEXT);
        checkValue("moved_sel", selA, 2);
        tick();
        op = 1'b0;
        tick();
        op = 1'b1;
        tick();
        checkValue("restore_chosen_sel", selA, 1);
        pressKey(K_ANEXT);
        tick();

        // reset lands between the confirm edge and its pulse
        aConf = 1'b1;
        tick();
        checkValue("pre_reset_confirmed", confA, 0);
        reset = 1'b1;
        tick();
        checkValue("reset_kills_pulse", confA, 0);
        checkValue("reset_chosen_default", chosenA, 0);
        checkValue("reset_sel_default", selA, 0);
        aConf = 1'b0;
        reset = 1'b0;
        tick();
        checkValue("post_reset_confirmed", confA, 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
